// File: rtl/game_session_ctrl.sv
// Session controller behind the ID handler: runs one player's login session, scores rounds
// from hit/miss pulses and keeps a 32-entry per-player high-score table.
`timescale 1ns/1ps
module game_session_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MatchedID,
    input  logic [4:0]         PlayerAddress,
    input  logic               StartButton,
    input  logic               LogoutButton,
    input  logic               HitPulse,
    input  logic               MissPulse,
    output logic               LogoutCommand_from_GC,
    output logic               GameActive,
    output logic [SCORE_W-1:0] Score,
    output logic [SCORE_W-1:0] HighScore,
    output logic               NewHighScore
);

    localparam int unsigned        TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [TimerW-1:0]  TimerOne  = TimerW'(1);
    localparam logic [2:0]         LivesInit = 3'(LIVES);
    localparam logic [SCORE_W-1:0] ScoreMax  = '1;
    localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);

    typedef enum logic [2:0] {
        StIdle, StReady, StPlay, StUpdate, StLogout, StWaitClr
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [4:0]         r_addr, w_addr_nxt;
    logic [TimerW-1:0]  r_timer, w_timer_nxt;
    logic [2:0]         r_lives, w_lives_nxt;
    logic               r_logout_pend, w_logout_pend_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic               r_new_hs, w_new_hs_nxt;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_logout_cmd;
    logic [SCORE_W-1:0] r_table [32];

    logic w_timeout;
    logic w_beat;
    logic w_tbl_we;

    assign w_timeout = (r_timer == TimerLast);
    assign w_beat    = (r_score > r_table[r_addr]);

    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_timer_nxt       = r_timer;
        w_lives_nxt       = r_lives;
        w_logout_pend_nxt = r_logout_pend;
        w_score_nxt       = r_score;
        w_new_hs_nxt      = r_new_hs;
        w_tbl_we          = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MatchedID) begin
                    w_addr_nxt   = PlayerAddress;
                    w_score_nxt  = '0;
                    w_new_hs_nxt = 1'b0;
                    w_timer_nxt  = '0;
                    w_state_nxt  = StReady;
                end
            end
            StReady: begin
                if (!MatchedID) begin
                    w_state_nxt = StIdle;
                end else if (LogoutButton || w_timeout) begin
                    w_state_nxt = StLogout;
                end else if (StartButton) begin
                    w_timer_nxt  = '0;
                    w_new_hs_nxt = 1'b0;
                    w_score_nxt  = '0;
                    w_lives_nxt  = LivesInit;
                    w_state_nxt  = StPlay;
                end else begin
                    w_timer_nxt = r_timer + TimerOne;
                end
            end
            StPlay: begin
                // An unsolicited drop leaves the round unrecorded and the score on display.
                if (!MatchedID) begin
                    w_state_nxt = StIdle;
                end else if (LogoutButton || w_timeout) begin
                    w_logout_pend_nxt = 1'b1;
                    w_state_nxt       = StUpdate;
                end else begin
                    if (HitPulse && (r_score != ScoreMax)) begin
                        w_score_nxt = r_score + ScoreOne;
                    end
                    if (MissPulse) begin
                        w_lives_nxt = r_lives - 3'd1;
                        if (r_lives == 3'd1) begin
                            w_state_nxt = StUpdate;
                        end
                    end
                    w_timer_nxt = (HitPulse || MissPulse) ? '0 : r_timer + TimerOne;
                end
            end
            StUpdate: begin
                if (w_beat) begin
                    w_tbl_we     = 1'b1;
                    w_new_hs_nxt = 1'b1;
                end
                if (r_logout_pend) begin
                    w_state_nxt = StLogout;
                end else begin
                    w_timer_nxt = '0;
                    w_state_nxt = StReady;
                end
            end
            StLogout: begin
                w_logout_pend_nxt = 1'b0;
                w_state_nxt       = StWaitClr;
            end
            StWaitClr: begin
                if (!MatchedID) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_timer       <= '0;
            r_lives       <= '0;
            r_logout_pend <= 1'b0;
            r_score       <= '0;
            r_new_hs      <= 1'b0;
            r_high_score  <= '0;
            r_logout_cmd  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_timer       <= w_timer_nxt;
            r_lives       <= w_lives_nxt;
            r_logout_pend <= w_logout_pend_nxt;
            r_score       <= w_score_nxt;
            r_new_hs      <= w_new_hs_nxt;
            // Bypass the write so HighScore shows a new record alongside NewHighScore.
            r_high_score  <= w_tbl_we ? r_score : r_table[r_addr];
            r_logout_cmd  <= (r_state == StLogout);
            if (w_tbl_we) begin
                r_table[r_addr] <= r_score;
            end
        end
    end

    assign LogoutCommand_from_GC = r_logout_cmd;
    assign GameActive            = (r_state == StPlay);
    assign Score                 = r_score;
    assign HighScore             = r_high_score;
    assign NewHighScore          = r_new_hs;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: a vector table for scored rounds, then hand-written
// sequences for logout, inactivity timeout, unsolicited drop, saturation and async reset.
`timescale 1ns/1ps
module tb_game_session_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       MatchedID;
    logic [4:0] PlayerAddress;
    logic       StartButton;
    logic       LogoutButton;
    logic       HitPulse;
    logic       MissPulse;
    logic       LogoutCommand_from_GC;
    logic       GameActive;
    logic [7:0] Score;
    logic [7:0] HighScore;
    logic       NewHighScore;

    int checks   = 0;
    int failures = 0;

    game_session_ctrl #(
        .TIMEOUT_CYCLES(20),
        .LIVES         (3),
        .SCORE_W       (8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .MatchedID            (MatchedID),
        .PlayerAddress        (PlayerAddress),
        .StartButton          (StartButton),
        .LogoutButton         (LogoutButton),
        .HitPulse             (HitPulse),
        .MissPulse            (MissPulse),
        .LogoutCommand_from_GC(LogoutCommand_from_GC),
        .GameActive           (GameActive),
        .Score                (Score),
        .HighScore            (HighScore),
        .NewHighScore         (NewHighScore)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       match;
        logic [4:0] addr;
        logic       start;
        logic       logout;
        logic       hit;
        logic       miss;
        logic       e_cmd;
        logic       e_active;
        logic [7:0] e_score;
        logic [7:0] e_hs;
        logic       e_nhs;
    } vec_t;

    localparam int NumVecs = 26;
    vec_t vecs [NumVecs];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic cmd, input logic act,
                             input logic [7:0] sc, input logic [7:0] hs, input logic nhs);
        check({name, ".cmd"}, int'(LogoutCommand_from_GC), int'(cmd));
        check({name, ".active"}, int'(GameActive), int'(act));
        check({name, ".score"}, int'(Score), int'(sc));
        check({name, ".hs"}, int'(HighScore), int'(hs));
        check({name, ".nhs"}, int'(NewHighScore), int'(nhs));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           m  addr start lo hit mis | cmd act score hs nhs
        vecs[0]  = '{1, 5'd5, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0};  // login -> READY
        vecs[1]  = '{1, 5'd5, 1, 0, 0, 0, 0, 1, 8'd0, 8'd0, 0};  // start
        vecs[2]  = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd1, 8'd0, 0};
        vecs[3]  = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd2, 8'd0, 0};
        vecs[4]  = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd3, 8'd0, 0};
        vecs[5]  = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd4, 8'd0, 0};
        vecs[6]  = '{1, 5'd5, 0, 0, 0, 1, 0, 1, 8'd4, 8'd0, 0};
        vecs[7]  = '{1, 5'd5, 0, 0, 0, 1, 0, 1, 8'd4, 8'd0, 0};
        vecs[8]  = '{1, 5'd5, 0, 0, 0, 1, 0, 0, 8'd4, 8'd0, 0};  // last life -> UPDATE
        vecs[9]  = '{1, 5'd5, 0, 0, 0, 0, 0, 0, 8'd4, 8'd4, 1};  // new record
        vecs[10] = '{1, 5'd5, 1, 0, 0, 0, 0, 1, 8'd0, 8'd4, 0};
        vecs[11] = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd1, 8'd4, 0};
        vecs[12] = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd2, 8'd4, 0};
        vecs[13] = '{1, 5'd5, 0, 0, 0, 1, 0, 1, 8'd2, 8'd4, 0};
        vecs[14] = '{1, 5'd5, 0, 0, 0, 1, 0, 1, 8'd2, 8'd4, 0};
        vecs[15] = '{1, 5'd5, 0, 0, 0, 1, 0, 0, 8'd2, 8'd4, 0};
        vecs[16] = '{1, 5'd5, 0, 0, 0, 0, 0, 0, 8'd2, 8'd4, 0};  // record kept
        vecs[17] = '{1, 5'd5, 1, 0, 0, 0, 0, 1, 8'd0, 8'd4, 0};
        vecs[18] = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd1, 8'd4, 0};
        vecs[19] = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd2, 8'd4, 0};
        vecs[20] = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd3, 8'd4, 0};
        vecs[21] = '{1, 5'd5, 0, 0, 1, 0, 0, 1, 8'd4, 8'd4, 0};
        vecs[22] = '{1, 5'd5, 0, 0, 0, 1, 0, 1, 8'd4, 8'd4, 0};
        vecs[23] = '{1, 5'd5, 0, 0, 0, 1, 0, 1, 8'd4, 8'd4, 0};
        vecs[24] = '{1, 5'd5, 0, 0, 1, 1, 0, 0, 8'd5, 8'd4, 0};  // hit+miss on last life
        vecs[25] = '{1, 5'd5, 0, 0, 0, 0, 0, 0, 8'd5, 8'd5, 1};

        rst           = 1'b1;
        MatchedID     = 1'b0;
        PlayerAddress = 5'd0;
        StartButton   = 1'b0;
        LogoutButton  = 1'b0;
        HitPulse      = 1'b0;
        MissPulse     = 1'b0;
        step();
        step();
        check_all("reset", 0, 0, 8'd0, 8'd0, 0);
        rst = 1'b0;
        step();
        check_all("idle", 0, 0, 8'd0, 8'd0, 0);

        for (int i = 0; i < NumVecs; i++) begin
            MatchedID     = vecs[i].match;
            PlayerAddress = vecs[i].addr;
            StartButton   = vecs[i].start;
            LogoutButton  = vecs[i].logout;
            HitPulse      = vecs[i].hit;
            MissPulse     = vecs[i].miss;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_active,
                      vecs[i].e_score, vecs[i].e_hs, vecs[i].e_nhs);
        end
        StartButton = 1'b0;
        HitPulse    = 1'b0;
        MissPulse   = 1'b0;

        // Logout mid-PLAY with score 7
        StartButton = 1'b1;
        step();
        StartButton = 1'b0;
        HitPulse    = 1'b1;
        repeat (7) step();
        HitPulse = 1'b0;
        check("lo.score7", int'(Score), 7);
        LogoutButton = 1'b1;
        step();
        LogoutButton = 1'b0;
        check_all("lo.update", 0, 0, 8'd7, 8'd5, 0);
        step();
        check_all("lo.written", 0, 0, 8'd7, 8'd7, 1);
        step();
        check("lo.pulse", int'(LogoutCommand_from_GC), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("lo.hold%0d", k), int'(LogoutCommand_from_GC), 0);
        end
        MatchedID = 1'b0;
        step();
        check("lo.idle", int'(LogoutCommand_from_GC), 0);

        // Inactivity timeout in READY
        MatchedID = 1'b1;
        step();
        check("to.login_nhs", int'(NewHighScore), 0);
        for (int k = 1; k <= 22; k++) begin
            step();
            check($sformatf("to.cyc%0d", k), int'(LogoutCommand_from_GC), (k == 21) ? 1 : 0);
        end
        MatchedID = 1'b0;
        step();

        // Start at cycle 10 suppresses the timeout; then drop MatchedID in PLAY
        MatchedID = 1'b1;
        step();
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("st.ready%0d", k), int'(LogoutCommand_from_GC), 0);
        end
        StartButton = 1'b1;
        step();
        StartButton = 1'b0;
        check("st.active", int'(GameActive), 1);
        for (int k = 11; k <= 22; k++) begin
            step();
            check($sformatf("st.play%0d", k), int'(LogoutCommand_from_GC), 0);
        end
        check("st.still_active", int'(GameActive), 1);
        HitPulse = 1'b1;
        repeat (9) step();
        HitPulse = 1'b0;
        check("drop.score9", int'(Score), 9);
        MatchedID = 1'b0;
        step();
        check_all("drop.idle", 0, 0, 8'd9, 8'd7, 0);
        step();
        check("drop.nopulse", int'(LogoutCommand_from_GC), 0);
        MatchedID = 1'b1;
        step();
        check("relog.score", int'(Score), 0);
        step();
        check("relog.hs_unchanged", int'(HighScore), 7);

        // Score saturation
        StartButton = 1'b1;
        step();
        StartButton = 1'b0;
        HitPulse    = 1'b1;
        repeat (300) step();
        HitPulse = 1'b0;
        check("sat.score", int'(Score), 255);
        MissPulse = 1'b1;
        repeat (3) step();
        MissPulse = 1'b0;
        check("sat.over", int'(GameActive), 0);
        step();
        check("sat.hs", int'(HighScore), 255);
        check("sat.nhs", int'(NewHighScore), 1);

        // Async reset mid-PLAY
        StartButton = 1'b1;
        step();
        StartButton = 1'b0;
        HitPulse    = 1'b1;
        repeat (2) step();
        HitPulse = 1'b0;
        check("rst.pre_score", int'(Score), 2);
        check("rst.pre_active", int'(GameActive), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst.async", 0, 0, 8'd0, 8'd0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("rst.relog_hs", int'(HighScore), 0);

        // Logout from READY: pulse one cycle after the button edge
        LogoutButton = 1'b1;
        step();
        LogoutButton = 1'b0;
        check("rdylo.n", int'(LogoutCommand_from_GC), 0);
        step();
        check("rdylo.n1", int'(LogoutCommand_from_GC), 1);
        step();
        check("rdylo.n2", int'(LogoutCommand_from_GC), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_session_ctrl.md
# game_session_ctrl

Session/game controller sitting directly downstream of the ID handler. It consumes `MatchedID` and `PlayerAddress`, runs one player's session, and scores game rounds from hit/miss pulses. It keeps a per-player high-score table and issues the one-cycle `LogoutCommand_from_GC` pulse back to the ID handler on timeout or explicit logout.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: inactivity cycles before forced logout (≥2).
- `LIVES`, default 3: misses allowed per round (1–7).
- `SCORE_W`, default 8: score and high-score width.
- `clk` in 1: single system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `MatchedID` in 1: level from the ID handler, high while a player is authenticated.
- `PlayerAddress` in 5: authenticated player index, valid while `MatchedID`=1.
- `StartButton` in 1: one-cycle pulse (debounced upstream), starts a round.
- `LogoutButton` in 1: one-cycle pulse, requests logout.
- `HitPulse` in 1: one-cycle pulse, successful hit.
- `MissPulse` in 1: one-cycle pulse, miss.
- `LogoutCommand_from_GC` out 1: one-cycle pulse to the ID handler.
- `GameActive` out 1: high in PLAY.
- `Score` out SCORE_W: current round score.
- `HighScore` out SCORE_W: stored best for the latched player.
- `NewHighScore` out 1: last round set a new record.

## Operation
- State machine: IDLE, READY, PLAY, UPDATE, LOGOUT, WAIT_CLR.
- Storage: 32-entry × SCORE_W high-score table, indexed by latched `addr_q`. The table resets to all zero and is **not** cleared by logout.
- IDLE, when `MatchedID`=1:
  - latch `PlayerAddress` into `addr_q`;
  - clear `Score` and `NewHighScore`;
  - go to READY.
- READY:
  - inactivity timer increments every cycle.
  - `StartButton`: clear timer and `NewHighScore`, `Score`←0, lives←LIVES, go to PLAY.
  - `LogoutButton` or timer = TIMEOUT_CYCLES−1: go to LOGOUT.
- PLAY:
  - `HitPulse`: `Score`+1, saturating at 2^SCORE_W−1.
  - `MissPulse`: lives−1. A miss with lives=1 sets game-over and goes to UPDATE.
  - Hit and miss in the same cycle: both apply.
  - Any hit or miss clears the timer.
  - `LogoutButton` or timeout: set `logout_pend`, go to UPDATE.
  - `StartButton` is ignored.
- UPDATE, exactly one cycle:
  - if `Score` > table[`addr_q`], write `Score` and set `NewHighScore`;
  - then go to LOGOUT if `logout_pend`, else READY with the timer cleared.
- LOGOUT: `LogoutCommand_from_GC`=1 for this single cycle, clear `logout_pend`, go to WAIT_CLR.
- WAIT_CLR: stay until `MatchedID`=0, then go to IDLE.
- `MatchedID` falling in READY or PLAY (unsolicited logout):
  - go straight to IDLE;
  - no table write, no logout pulse, `Score` held.
- Input priority in a single cycle: `MatchedID` drop > `LogoutButton` > timeout > `StartButton`/hit/miss.
- Widths:
  - timer is $clog2(TIMEOUT_CYCLES) bits;
  - lives is 3 bits;
  - score compare is unsigned.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0;
  - `addr_q`, timer, lives and `logout_pend` all 0.
- Login latency: `MatchedID` high at edge N puts the block in READY after N. `HighScore` is valid from N+1 as a registered table read.
- `StartButton` at edge N: `GameActive`=1 and `Score`=0 after N.
- Hit at edge N: `Score` updated after N.
- Final miss at edge N: `GameActive`=0 after N (UPDATE). Table and `NewHighScore` update after N+1.
- Logout from READY: `LogoutButton` at edge N gives the `LogoutCommand_from_GC` pulse during cycle N+1→N+2.
- Logout from PLAY: the pulse comes one cycle later because of UPDATE.
- Timeout in READY: the timeout fires at the edge where the timer reaches TIMEOUT_CYCLES−1, i.e. after exactly TIMEOUT_CYCLES idle cycles in READY.
- The `LogoutCommand_from_GC` pulse is never longer than one cycle, even if `MatchedID` stays high.
- Async `rst` mid-round: immediate return to IDLE and all-zero table.

## Test plan
- Sim parameters: TIMEOUT_CYCLES=20, LIVES=3.
- Login and round: `MatchedID`=1 with `PlayerAddress`=5, Start, 4 hits, 3 misses → `Score`=4, `GameActive`=0, `NewHighScore`=1, `HighScore`=4, state READY.
- Record kept: same player plays again with 2 hits then 3 misses → `HighScore` stays 4, `NewHighScore`=0.
- Logout mid-PLAY: score 7, `LogoutButton` → table[5]=7, single `LogoutCommand_from_GC` pulse 2 cycles later. Hold `MatchedID` high 5 more cycles → no second pulse. Drop it → IDLE.
- Inactivity: login, no input → `LogoutCommand_from_GC` pulse 21 cycles after entering READY. One Start at cycle 10 instead → no pulse during READY.
- Edge cases:
  - simultaneous Hit+Miss with lives=1 → `Score`+1 recorded, round ends.
  - 300 hits with SCORE_W=8 → `Score`=255.
  - `MatchedID` dropped in PLAY → IDLE, table unchanged.
- Async `rst` asserted mid-PLAY → all outputs 0 immediately. Re-login as player 5 → `HighScore`=0.
